bram_hw_arbiter: RTL and testbench
==================================

Name: bram_hw_arbiter

Overview:
- Shares one BlockRAM_1KB instance between two requesters (m0, m1). Each requester sees a 512 x 16-bit halfword memory with a valid/ready request channel and an in-order read-response channel.
- Drives the RAM's packed control fields: write enable, halfword select and read-lane select.
- Arbitrates round-robin at one operation per cycle.
- Optionally zero-fills the whole RAM after reset before accepting traffic.

Parameters:
- OUT_REG, 0: value driven on C5. 1 = RAM output register used, which adds 1 cycle of read latency.
- INIT_CLEAR, 1: 1 = clear all 512 halfwords after reset; 0 = go straight to RUN.
- WE_BIT, 20: bit of ram_wr_data that is the RAM write enable (1 = write).
- WR_HALF_BIT, 16: bit of ram_wr_data that selects the write halfword (0 = [15:0], 1 = [31:16]).
- RD_HALF_BIT, 24: bit of ram_wr_data that selects the read halfword lane.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req_valid  in  1  m0 request valid
- m0_req_we  in  1  1 = write, 0 = read
- m0_req_addr  in  9  halfword address; [8:1] = word, [0] = half
- m0_req_wdata  in  16  write data
- m0_req_ready  out  1  m0 request accepted this cycle when high together with valid
- m0_rsp_valid  out  1  m0 read data valid
- m0_rsp_rdata  out  16  m0 read data
- m1_* : same seven ports as m0
- ram_rd_addr  out  8  to BlockRAM rd_addr
- ram_wr_addr  out  8  to BlockRAM wr_addr
- ram_wr_data  out  32  to BlockRAM wr_data (packed)
- ram_cfg  out  6  to {C5..C0}; constant {OUT_REG,1'b0,2'b01,2'b01}, i.e. 16-bit write, 16-bit read, dynamic write enable
- ram_rd_data  in  32  from BlockRAM rd_data; only [15:0] is used
- init_done  out  1  high once RUN is entered

Behaviour:
- Reset state (rst_n low):
  - FSM = INIT if INIT_CLEAR, else RUN.
  - init counter = 0, round-robin pointer = m0 preferred.
  - req_ready = 0 and rsp_valid = 0 for both requesters.
  - init_done = 0.
  - ram_wr_data = 0, so WE = 0 and no write occurs.
  - ram_rd_addr = 0, ram_wr_addr = 0.
- FSM INIT:
  - Each cycle, write 0 to halfword cnt[8:0]: ram_wr_addr = cnt[8:1], WR_HALF_BIT = cnt[0], WE = 1.
  - Counter increments each cycle; after cnt = 511 the FSM moves to RUN (512 cycles total).
  - Both req_ready stay 0 throughout INIT.
- FSM RUN:
  - init_done = 1.
  - Grant is combinational from the current valids and the pointer.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that did not receive the last grant is granted.
  - The pointer updates only on a grant.
  - req_ready = grant for each requester; a request is accepted when valid && ready.
- Write accepted in cycle T:
  - ram_wr_addr = addr[8:1]; WE = 1; WR_HALF_BIT = addr[0]; ram_wr_data[15:0] = wdata.
  - The RAM is written at the end of T.
- Read accepted in cycle T:
  - ram_rd_addr = addr[8:1]; RD_HALF_BIT = addr[0]; WE = 0.
  - The requester ID is pushed into a response pipeline of depth 1+OUT_REG.
  - rsp_valid is high in cycle T+1+OUT_REG for exactly 1 cycle, for that requester only.
  - rsp_rdata = ram_rd_data[15:0] for both requesters; it is meaningful only while that requester's rsp_valid is high.
- No grant in a cycle:
  - WE = 0.
  - Address and select fields hold their previous values, to avoid glitching the RAM read mux.
- Ordering and hazards:
  - One operation per cycle, so the single RAM port pair never sees a same-address read/write collision.
  - A read issued the cycle after a write to the same halfword returns the new data.
  - Back-to-back reads sustain 1 response per cycle; responses return in issue order.
- Requester valid may drop without ready; nothing is accepted in that case.
- Reset asserted mid-operation:
  - In-flight responses are discarded; no rsp_valid is produced after reset.
  - INIT restarts from 0.
- All unused ram_wr_data bits are driven 0.

Decomposition:
- Shared package bram_ctrl_pkg:
  - FSM state enum {ST_INIT, ST_RUN}.
  - Config constants: CFG_WR16 = 2'b01, CFG_RD16 = 2'b01.
  - Default field-bit constants, matching the BlockRAM defaults (20/16/24).
  - Halfword count constant 512.
- One natural sub-module, rr_arb2: the 2-way round-robin arbiter with pointer register (clk, rst_n, req[1:0] -> gnt[1:0]).

Test Plan:
- Reset with INIT_CLEAR=1 -> init_done rises exactly 512 cycles after rst_n deasserts; both req_ready stay 0 until then; reading addr 0x1FF then returns 0x0000.
- m0 writes 0xBEEF to addr 0x003, then reads 0x003 the next cycle -> one cycle each direction:
  - write cycle: ram_wr_addr = 0x01, WR_HALF_BIT = 1, WE = 1;
  - m0_rsp_valid pulses 1 cycle after the read is accepted (OUT_REG=0) with rdata 0xBEEF;
  - m1_rsp_valid stays 0.
- Both requesters hold valid reads for 4 cycles -> grants alternate m0, m1, m0, m1; responses return in the same order; no requester is starved.
- OUT_REG=1, 3 back-to-back m1 reads of addrs 0x010/0x011/0x012 (preloaded 0x1111/0x2222/0x3333) -> m1_rsp_valid high for 3 consecutive cycles starting 2 cycles after the first accept, data in order; ram_cfg[5] = 1.
- Assert rst_n low the cycle after a read is accepted -> no rsp_valid ever appears; ram_wr_data = 0 while reset is held; INIT restarts from address 0.
- m0 valid dropped without ready while m1 holds the grant -> m0 op not executed; the memory content at m0's address is unchanged when read back.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared FSM states, BlockRAM config codes and field-bit defaults
package bram_ctrl_pkg;
    typedef enum logic {ST_INIT, ST_RUN} state_e;
    localparam logic [1:0] CFG_WR16 = 2'b01;
    localparam logic [1:0] CFG_RD16 = 2'b01;
    localparam int DEF_WE_BIT = 20;
    localparam int DEF_WR_HALF_BIT = 16;
    localparam int DEF_RD_HALF_BIT = 24;
    localparam int HW_COUNT = 512;
    localparam int CNT_W = $clog2(HW_COUNT);
endpackage

// File: rtl/bram_hw_arbiter_if.sv
// bram_hw_arbiter_if: one requester's halfword request channel and in-order read-response channel
// master = requester side (drives req_valid/req_we/req_addr/req_wdata), slave = arbiter side
interface bram_hw_arbiter_if;
    logic req_valid;
    logic req_we;
    logic [8:0] req_addr;
    logic [15:0] req_wdata;
    logic req_ready;
    logic rsp_valid;
    logic [15:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bram_hw_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter, combinational grant, pointer moves only on a grant
// clk/rst_n: clock and async active-low reset; req[1:0]: requests; gnt[1:0]: one-hot grant
module rr_arb2 (
    input logic clk,
    input logic rst_n,
    input logic [1:0] req,
    output logic [1:0] gnt
);
    // last_q = 1 means requester 1 was granted last, so requester 0 wins the next tie
    logic last_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last_q <= 1'b1;
        else if (|gnt)
            last_q <= gnt[1];
    assign gnt[0] = req[0] & (~req[1] | last_q);
    assign gnt[1] = req[1] & (~req[0] | ~last_q);
endmodule

// File: rtl/bram_hw_arbiter.sv
// bram_hw_arbiter: shares one BlockRAM_1KB between two 512x16 halfword requesters
// clk/rst_n: clock, async active-low reset; m0/m1: requester channels (slave modport)
// ram_rd_addr/ram_wr_addr/ram_wr_data/ram_cfg: BlockRAM drive; ram_rd_data: BlockRAM read data
// init_done: high once the optional zero-fill has finished and traffic is accepted
module bram_hw_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter bit OUT_REG = 1'b0,
    parameter bit INIT_CLEAR = 1'b1,
    parameter int WE_BIT = DEF_WE_BIT,
    parameter int WR_HALF_BIT = DEF_WR_HALF_BIT,
    parameter int RD_HALF_BIT = DEF_RD_HALF_BIT
) (
    input logic clk,
    input logic rst_n,
    bram_hw_arbiter_if.slave m0,
    bram_hw_arbiter_if.slave m1,
    output logic [7:0] ram_rd_addr,
    output logic [7:0] ram_wr_addr,
    output logic [31:0] ram_wr_data,
    output logic [5:0] ram_cfg,
    input logic [31:0] ram_rd_data,
    output logic init_done
);
    localparam int D = int'(OUT_REG) + 1;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] req, gnt;
    logic run, op, op_we, rd_acc;
    logic [8:0] op_addr;
    logic [15:0] op_wdata;
    logic [7:0] wr_addr_q, rd_addr_q, wr_addr, rd_addr;
    logic wr_half_q, rd_half_q, wr_half, rd_half, we;
    logic [15:0] wdata_q, wdata;
    logic [D-1:0] pv_q, pid_q;
    logic unused_hi;
    // rst_n is folded in so nothing is granted or written while reset is held
    assign run = rst_n && state_q == ST_RUN;
    assign init_done = run;
    assign req = {m1.req_valid, m0.req_valid} & {2{run}};
    rr_arb2 u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt)
    );
    assign m0.req_ready = gnt[0];
    assign m1.req_ready = gnt[1];
    assign op = |gnt;
    assign op_we = gnt[1] ? m1.req_we : m0.req_we;
    assign op_addr = gnt[1] ? m1.req_addr : m0.req_addr;
    assign op_wdata = gnt[1] ? m1.req_wdata : m0.req_wdata;
    assign rd_acc = op && !op_we;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    // Idle cycles reuse the last driven address/select values so the RAM read mux never glitches
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        we = 1'b0;
        wr_addr = wr_addr_q;
        wr_half = wr_half_q;
        wdata = wdata_q;
        rd_addr = rd_addr_q;
        rd_half = rd_half_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            state_d = &cnt_q ? ST_RUN : ST_INIT;
            if (rst_n) begin
                we = 1'b1;
                wr_addr = cnt_q[CNT_W-1:1];
                wr_half = cnt_q[0];
                wdata = '0;
            end
        end else if (op && op_we) begin
            we = 1'b1;
            wr_addr = op_addr[8:1];
            wr_half = op_addr[0];
            wdata = op_wdata;
        end else if (op) begin
            rd_addr = op_addr[8:1];
            rd_half = op_addr[0];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_half_q <= 1'b0;
            rd_half_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            wr_addr_q <= wr_addr;
            rd_addr_q <= rd_addr;
            wr_half_q <= wr_half;
            rd_half_q <= rd_half;
            wdata_q <= wdata;
        end
    always_comb begin
        ram_wr_data = '0;
        ram_wr_data[15:0] = wdata;
        ram_wr_data[WE_BIT] = we;
        ram_wr_data[WR_HALF_BIT] = wr_half;
        ram_wr_data[RD_HALF_BIT] = rd_half;
    end
    assign ram_rd_addr = rd_addr;
    assign ram_wr_addr = wr_addr;
    assign ram_cfg = {OUT_REG, 1'b0, CFG_RD16, CFG_WR16};
    // Response tag shift register: bit 0 is the newest read, bit D-1 lines up with RAM data
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pv_q <= '0;
            pid_q <= '0;
        end else begin
            pv_q <= D'({pv_q, rd_acc});
            pid_q <= D'({pid_q, gnt[1]});
        end
    assign m0.rsp_valid = pv_q[D-1] & ~pid_q[D-1];
    assign m1.rsp_valid = pv_q[D-1] & pid_q[D-1];
    assign m0.rsp_rdata = ram_rd_data[15:0];
    assign m1.rsp_rdata = ram_rd_data[15:0];
    assign unused_hi = ^ram_rd_data[31:16];
endmodule

// File: tb/tb_bram_hw_arbiter.sv
// tb_bram_hw_arbiter: directed self-checking bench with a behavioural BlockRAM per DUT
module tb_bram_hw_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    bram_hw_arbiter_if a0 ();
    bram_hw_arbiter_if a1 ();
    bram_hw_arbiter_if b0 ();
    bram_hw_arbiter_if b1 ();
    logic [7:0] a_ra, a_wa, b_ra, b_wa;
    logic [31:0] a_wd, a_rd, b_wd, b_rd;
    logic [5:0] a_cfg, b_cfg;
    logic a_done, b_done;
    bram_hw_arbiter #(.OUT_REG(1'b0), .INIT_CLEAR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1),
        .ram_rd_addr(a_ra), .ram_wr_addr(a_wa), .ram_wr_data(a_wd),
        .ram_cfg(a_cfg), .ram_rd_data(a_rd), .init_done(a_done)
    );
    bram_hw_arbiter #(.OUT_REG(1'b1), .INIT_CLEAR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .m0(b0), .m1(b1),
        .ram_rd_addr(b_ra), .ram_wr_addr(b_wa), .ram_wr_data(b_wd),
        .ram_cfg(b_cfg), .ram_rd_data(b_rd), .init_done(b_done)
    );
    // BlockRAM models: registered read, optional output register, write enable/half from packed fields
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [15:0] rq_a, rq_b, rq2_b;
    always @(posedge clk) begin
        if (a_wd[20]) begin
            if (a_wd[16]) mem_a[a_wa][31:16] <= a_wd[15:0];
            else mem_a[a_wa][15:0] <= a_wd[15:0];
        end
        rq_a <= a_wd[24] ? mem_a[a_ra][31:16] : mem_a[a_ra][15:0];
        if (b_wd[20]) begin
            if (b_wd[16]) mem_b[b_wa][31:16] <= b_wd[15:0];
            else mem_b[b_wa][15:0] <= b_wd[15:0];
        end
        rq_b <= b_wd[24] ? mem_b[b_ra][31:16] : mem_b[b_ra][15:0];
        rq2_b <= rq_b;
    end
    assign a_rd = {16'h0, rq_a};
    assign b_rd = {16'h0, rq2_b};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        a0.req_valid = 0; a0.req_we = 0; a0.req_addr = '0; a0.req_wdata = '0;
        a1.req_valid = 0; a1.req_we = 0; a1.req_addr = '0; a1.req_wdata = '0;
        b0.req_valid = 0; b0.req_we = 0; b0.req_addr = '0; b0.req_wdata = '0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0;
    endtask

    task automatic test_reset;
        idle_all();
        a0.req_valid = 1; a0.req_addr = 9'h1FF;
        tick(); tick(); #1;
        total++; if (a_wd !== 32'h0) begin bad++; $display("FAIL reset_wd: got %h want 0", a_wd); end
        total++; if (a0.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", a0.req_ready); end
        total++; if (a_done !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b%b want 00", a_done, b_done); end
        total++; if (a_ra !== 8'h0 || a_wa !== 8'h0) begin bad++; $display("FAIL reset_addr: got %h/%h want 00/00", a_ra, a_wa); end
        total++; if (a0.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp: got %b want 0", a0.rsp_valid); end
        total++; if (a_cfg !== 6'b000101) begin bad++; $display("FAIL cfg_a: got %b want 000101", a_cfg); end
        total++; if (b_cfg !== 6'b100101) begin bad++; $display("FAIL cfg_b: got %b want 100101", b_cfg); end
        tick(); rst_n = 1; #1;
        total++; if (a_wd !== 32'h0010_0000 || a_wa !== 8'h00) begin bad++; $display("FAIL init_first: got %h@%h want 00100000@00", a_wd, a_wa); end
        total++; if (b_done !== 1'b1) begin bad++; $display("FAIL noinit_done: got %b want 1", b_done); end
        for (int k = 1; k <= 512; k++) begin
            tick(); #1;
            if (k == 3) begin
                total++; if (a_wd !== 32'h0011_0000 || a_wa !== 8'h01) begin bad++; $display("FAIL init_cnt3: got %h@%h want 00110000@01", a_wd, a_wa); end
            end
            total++; if (a_done !== (k == 512)) begin bad++; $display("FAIL init_done k=%0d: got %b want %b", k, a_done, k == 512); end
            total++; if (a0.req_ready !== (k == 512)) begin bad++; $display("FAIL init_ready k=%0d: got %b want %b", k, a0.req_ready, k == 512); end
        end
        total++; if (a_ra !== 8'hFF || a_wd !== 32'h0101_0000) begin bad++; $display("FAIL rd1ff_bus: got %h/%h want ff/01010000", a_ra, a_wd); end
        tick(); a0.req_valid = 0; #1;
        total++; if (a0.rsp_valid !== 1'b1 || a0.rsp_rdata !== 16'h0000) begin bad++; $display("FAIL rd1ff_rsp: got %b/%h want 1/0000", a0.rsp_valid, a0.rsp_rdata); end
    endtask

    task automatic test_write_read;
        tick(); a0.req_valid = 1; a0.req_we = 1; a0.req_addr = 9'h003; a0.req_wdata = 16'hBEEF; #1;
        total++; if (a0.req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", a0.req_ready); end
        total++; if (a_wa !== 8'h01 || a_wd !== 32'h0111_BEEF) begin bad++; $display("FAIL wr_bus: got %h/%h want 01/0111beef", a_wa, a_wd); end
        tick(); a0.req_we = 0; #1;
        total++; if (a_ra !== 8'h01 || a_wd !== 32'h0101_BEEF) begin bad++; $display("FAIL rd_bus: got %h/%h want 01/0101beef", a_ra, a_wd); end
        tick(); a0.req_valid = 0; #1;
        total++; if (a0.rsp_valid !== 1'b1 || a0.rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_rsp: got %b/%h want 1/beef", a0.rsp_valid, a0.rsp_rdata); end
        total++; if (a1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_m1: got %b want 0", a1.rsp_valid); end
        total++; if (a_ra !== 8'h01 || a_wd !== 32'h0101_BEEF) begin bad++; $display("FAIL idle_hold: got %h/%h want 01/0101beef", a_ra, a_wd); end
        tick(); #1;
        total++; if (a0.rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", a0.rsp_valid); end
    endtask

    task automatic test_alternate;
        a1.req_valid = 1; a1.req_we = 1; a1.req_addr = 9'h010; a1.req_wdata = 16'hA1A1; #1;
        total++; if (a1.req_ready !== 1'b1 || a0.req_ready !== 1'b0) begin bad++; $display("FAIL pre_ready: got %b%b want 10", a1.req_ready, a0.req_ready); end
        total++; if (a_wa !== 8'h08 || a_wd !== 32'h0110_A1A1) begin bad++; $display("FAIL pre_bus: got %h/%h want 08/0110a1a1", a_wa, a_wd); end
        for (int c = 0; c <= 4; c++) begin
            tick();
            a0.req_valid = (c < 4); a0.req_we = 0; a0.req_addr = 9'h003;
            a1.req_valid = (c < 4); a1.req_we = 0; a1.req_addr = 9'h010;
            #1;
            if (c < 4) begin
                total++; if (a0.req_ready !== (c % 2 == 0) || a1.req_ready !== (c % 2 == 1)) begin bad++; $display("FAIL alt_gnt c=%0d: got %b%b want %b%b", c, a1.req_ready, a0.req_ready, c % 2 == 1, c % 2 == 0); end
            end
            if (c == 0) begin
                total++; if (a0.rsp_valid !== 1'b0 || a1.rsp_valid !== 1'b0) begin bad++; $display("FAIL alt_rsp0: got %b%b want 00", a1.rsp_valid, a0.rsp_valid); end
            end else begin
                total++; if (a0.rsp_valid !== (c % 2 == 1) || a1.rsp_valid !== (c % 2 == 0)) begin bad++; $display("FAIL alt_rsp c=%0d: got %b%b want %b%b", c, a1.rsp_valid, a0.rsp_valid, c % 2 == 0, c % 2 == 1); end
                total++; if (a0.rsp_rdata !== ((c % 2 == 1) ? 16'hBEEF : 16'hA1A1)) begin bad++; $display("FAIL alt_data c=%0d: got %h", c, a0.rsp_rdata); end
            end
        end
    endtask

    task automatic test_valid_drop;
        tick(); a0.req_valid = 1; a0.req_we = 0; a0.req_addr = 9'h003; #1;
        total++; if (a0.req_ready !== 1'b1) begin bad++; $display("FAIL drop_first: got %b want 1", a0.req_ready); end
        tick(); a0.req_we = 1; a0.req_wdata = 16'hDEAD;
        a1.req_valid = 1; a1.req_we = 0; a1.req_addr = 9'h010; #1;
        total++; if (a0.req_ready !== 1'b0 || a1.req_ready !== 1'b1) begin bad++; $display("FAIL drop_gnt: got %b%b want 10", a1.req_ready, a0.req_ready); end
        total++; if (a_wd[20] !== 1'b0) begin bad++; $display("FAIL drop_we: got %b want 0", a_wd[20]); end
        total++; if (a0.rsp_valid !== 1'b1 || a0.rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL drop_rsp0: got %b/%h want 1/beef", a0.rsp_valid, a0.rsp_rdata); end
        tick(); a0.req_valid = 0; a1.req_valid = 0; #1;
        total++; if (a1.rsp_valid !== 1'b1 || a0.rsp_valid !== 1'b0 || a1.rsp_rdata !== 16'hA1A1) begin bad++; $display("FAIL drop_rsp1: got %b%b/%h want 10/a1a1", a1.rsp_valid, a0.rsp_valid, a1.rsp_rdata); end
        tick(); a0.req_valid = 1; a0.req_we = 0; a0.req_addr = 9'h003; #1;
        total++; if (a0.req_ready !== 1'b1) begin bad++; $display("FAIL drop_rb_ready: got %b want 1", a0.req_ready); end
        tick(); a0.req_valid = 0; #1;
        total++; if (a0.rsp_valid !== 1'b1 || a0.rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL drop_readback: got %b/%h want 1/beef", a0.rsp_valid, a0.rsp_rdata); end
    endtask

    task automatic test_outreg;
        logic [15:0] d3 [3];
        d3[0] = 16'h1111; d3[1] = 16'h2222; d3[2] = 16'h3333;
        for (int c = 0; c < 3; c++) begin
            tick(); b1.req_valid = 1; b1.req_we = 1; b1.req_addr = 9'h010 + 9'(c); b1.req_wdata = d3[c]; #1;
            total++; if (b1.req_ready !== 1'b1 || b_wa !== 8'((9'h010 + 9'(c)) >> 1)) begin bad++; $display("FAIL or_wr c=%0d: got %b/%h", c, b1.req_ready, b_wa); end
        end
        for (int c = 0; c <= 5; c++) begin
            tick(); b1.req_valid = (c < 3); b1.req_we = 0; b1.req_addr = 9'h010 + 9'(c % 3); #1;
            if (c < 3) begin
                total++; if (b1.req_ready !== 1'b1) begin bad++; $display("FAIL or_rd_ready c=%0d: got %b want 1", c, b1.req_ready); end
            end
            total++; if (b1.rsp_valid !== (c >= 2 && c <= 4) || b0.rsp_valid !== 1'b0) begin bad++; $display("FAIL or_rsp c=%0d: got %b%b want %b0", c, b1.rsp_valid, b0.rsp_valid, c >= 2 && c <= 4); end
            if (c >= 2 && c <= 4) begin
                total++; if (b1.rsp_rdata !== d3[c-2]) begin bad++; $display("FAIL or_data c=%0d: got %h want %h", c, b1.rsp_rdata, d3[c-2]); end
            end
        end
    endtask

    task automatic test_reset_midop;
        tick(); a0.req_valid = 1; a0.req_we = 0; a0.req_addr = 9'h003; #1;
        total++; if (a0.req_ready !== 1'b1) begin bad++; $display("FAIL mid_accept: got %b want 1", a0.req_ready); end
        tick(); rst_n = 0; #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (a0.rsp_valid !== 1'b0 || a1.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp c=%0d: got %b%b want 00", c, a1.rsp_valid, a0.rsp_valid); end
            total++; if (a_wd !== 32'h0 || a0.req_ready !== 1'b0) begin bad++; $display("FAIL mid_quiet c=%0d: got %h/%b want 0/0", c, a_wd, a0.req_ready); end
            tick();
        end
        a0.req_valid = 0; rst_n = 1; #1;
        total++; if (a_wd !== 32'h0010_0000 || a_wa !== 8'h00) begin bad++; $display("FAIL mid_init0: got %h@%h want 00100000@00", a_wd, a_wa); end
        tick(); #1;
        total++; if (a_wd !== 32'h0011_0000 || a_wa !== 8'h00) begin bad++; $display("FAIL mid_init1: got %h@%h want 00110000@00", a_wd, a_wa); end
        total++; if (a0.rsp_valid !== 1'b0 || a_done !== 1'b0) begin bad++; $display("FAIL mid_after: got %b/%b want 0/0", a0.rsp_valid, a_done); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_valid_drop();
        test_outreg();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
